// File: rtl/uart_pkg.sv
// Shared definitions for the SPART receive path: state encoding, default
// frame geometry and processor register map.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;
  localparam logic [1:0]  IOADDR_DATA    = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Width of a counter that must reach n (data-bit counter)
  function automatic int unsigned bit_cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  localparam int unsigned BIT_CNT_W = bit_cnt_w(DATA_BITS_DEF);

endpackage

// File: rtl/find_rising_edge.sv
// Registered single-cycle pulse on each rising edge of a same-clock input.
module find_rising_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
      o_rise <= 1'b0;
    end else begin
      r_prev <= i_sig;
      o_rise <= i_sig & ~r_prev;
    end
  end

endmodule

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rxd line plus a falling-edge
// detector aligned with the synchronised output.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic rxd_fall
);

  logic r_sync1;
  logic r_sync2;

  // Idle-high reset keeps a released line from looking like a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      rxd_fall <= 1'b0;
    end else begin
      r_sync1  <= rxd;
      r_sync2  <= r_sync1;
      rxd_fall <= r_sync2 & ~r_sync1;
    end
  end

  assign rxd_s = r_sync2;

endmodule

// File: rtl/uart_rx.sv
// SPART receiver: oversampled 8N1 deserialiser with a processor read port.
// Optional macro UART_RX_FRAMING_CHECK_EN discards frames whose stop bit is 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rx_en,
  input  logic                 iocs,
  input  logic                 iorw,
  input  logic [1:0]           ioaddr,
  output logic [DATA_BITS-1:0] receive_buffer,
  output logic                 rda
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = bit_cnt_w(DATA_BITS);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic w_tick;
  logic w_rxd_s;
  logic w_rxd_fall;
  logic w_rd_data;

  rx_state_e             r_state;
  logic [TICK_W-1:0]     r_tick_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;

  find_rising_edge u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (rx_en),
    .o_rise (w_tick)
  );

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rxd_s    (w_rxd_s),
    .rxd_fall (w_rxd_fall)
  );

  assign w_rd_data = iocs & iorw & (ioaddr == IOADDR_DATA);

  // Receive FSM; a load later in the block overrides a coincident read clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_tick_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      receive_buffer <= '0;
      rda            <= 1'b0;
    end else begin
      if (w_rd_data) begin
        rda <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_rxd_fall) begin
            r_state    <= ST_START;
            r_tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_tick_cnt == HALF_LAST) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_state    <= w_rxd_s ? ST_IDLE : ST_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == FULL_LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
              r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
              if (r_bit_cnt == BIT_LAST) begin
                r_state <= ST_STOP;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_tick_cnt == FULL_LAST) begin
              r_tick_cnt <= '0;
              r_state    <= ST_IDLE;
`ifdef UART_RX_FRAMING_CHECK_EN
              if (w_rxd_s) begin
                receive_buffer <= r_shift;
                rda            <= 1'b1;
              end
`else
              receive_buffer <= r_shift;
              rda            <= 1'b1;
`endif
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
